// File: rtl/execute_pkg.sv
// Shared EXEC-stage types: opcodes, IR source codes, NOP, ALU function codes.
// Also holds the opcode decoder used by the EXEC stage.
package execute_pkg;

  localparam logic [1:0] IR_SRC_DATA = 2'd0;
  localparam logic [1:0] IR_SRC_NOP  = 2'd1;

  // ADD R31,R31,R31
  localparam logic [31:0] NOP = 32'h83FF_F800;

  localparam logic [5:0] OP_LD  = 6'h18;
  localparam logic [5:0] OP_ST  = 6'h19;
  localparam logic [5:0] OP_JMP = 6'h1B;
  localparam logic [5:0] OP_BEQ = 6'h1C;
  localparam logic [5:0] OP_BNE = 6'h1D;
  localparam logic [5:0] OP_LDR = 6'h1F;

  // ALU function codes equal the low nibble of the 0x2x/0x3x opcodes
  typedef enum logic [3:0] {
    FN_ADD   = 4'h0,
    FN_SUB   = 4'h1,
    FN_MUL   = 4'h2,
    FN_DIV   = 4'h3,
    FN_CMPEQ = 4'h4,
    FN_CMPLT = 4'h5,
    FN_CMPLE = 4'h6,
    FN_RSV7  = 4'h7,
    FN_AND   = 4'h8,
    FN_OR    = 4'h9,
    FN_XOR   = 4'hA,
    FN_XNOR  = 4'hB,
    FN_SHL   = 4'hC,
    FN_SHR   = 4'hD,
    FN_SRA   = 4'hE,
    FN_RSVF  = 4'hF
  } alu_fn_e;

  typedef enum logic [1:0] {
    SEL_ZERO,
    SEL_ALU,
    SEL_PC,
    SEL_LDR
  } y_sel_e;

  typedef struct packed {
    alu_fn_e fn;
    y_sel_e  sel;
  } ex_ctl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ir;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] st;
  } ex_regs_t;

  function automatic ex_ctl_t decode(input logic [5:0] op);
    ex_ctl_t c;
    c.fn  = FN_ADD;
    c.sel = SEL_ZERO;
    if (op[5]) begin
      c.fn  = alu_fn_e'(op[3:0]);
      c.sel = SEL_ALU;
    end else begin
      case (op)
        OP_LD, OP_ST:           c.sel = SEL_ALU;
        OP_JMP, OP_BEQ, OP_BNE: c.sel = SEL_PC;
        OP_LDR:                 c.sel = SEL_LDR;
        default:                c.sel = SEL_ZERO;
      endcase
    end
    return c;
  endfunction

endpackage

// File: rtl/execute_if.sv
// RF->EXEC inputs and EXEC->MEM outputs of the EXEC stage.
// The stage takes the slave side; the RF/MEM side (or a bench) is master.
interface execute_if;
  import execute_pkg::*;

  logic [1:0]  ir_src_exec;
  logic [31:0] pc_exec_next;
  logic [31:0] ir_exec_next;
  logic [31:0] a_exec_next;
  logic [31:0] b_exec_next;
  logic [31:0] st_exec_next;

  logic [31:0] pc_mem_next;
  logic [31:0] ir_mem_next;
  logic [31:0] y_mem_next;
  logic [31:0] st_mem_next;

  modport master (
    output ir_src_exec,
    output pc_exec_next,
    output ir_exec_next,
    output a_exec_next,
    output b_exec_next,
    output st_exec_next,
    input  pc_mem_next,
    input  ir_mem_next,
    input  y_mem_next,
    input  st_mem_next
  );

  modport slave (
    input  ir_src_exec,
    input  pc_exec_next,
    input  ir_exec_next,
    input  a_exec_next,
    input  b_exec_next,
    input  st_exec_next,
    output pc_mem_next,
    output ir_mem_next,
    output y_mem_next,
    output st_mem_next
  );

endinterface

// File: rtl/execute_alu.sv
// Combinational 32-bit Beta ALU; DIV and reserved codes yield zero.
module execute_alu
  import execute_pkg::*;
(
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  alu_fn_e     fn_i,
  output logic [31:0] y_o
);

  logic [4:0] sh;
  logic       lt;
  logic       eq;

  assign sh = b_i[4:0];
  assign lt = $signed(a_i) < $signed(b_i);
  assign eq = a_i == b_i;

  always_comb begin
    y_o = '0;
    unique case (fn_i)
      FN_ADD:   y_o = a_i + b_i;
      FN_SUB:   y_o = a_i - b_i;
      FN_MUL:   y_o = a_i * b_i;
      FN_CMPEQ: y_o = {31'd0, eq};
      FN_CMPLT: y_o = {31'd0, lt};
      FN_CMPLE: y_o = {31'd0, lt | eq};
      FN_AND:   y_o = a_i & b_i;
      FN_OR:    y_o = a_i | b_i;
      FN_XOR:   y_o = a_i ^ b_i;
      FN_XNOR:  y_o = ~(a_i ^ b_i);
      FN_SHL:   y_o = a_i << sh;
      FN_SHR:   y_o = a_i >> sh;
      FN_SRA:   y_o = $unsigned($signed(a_i) >>> sh);
      default:  y_o = '0;
    endcase
  end

endmodule

// File: rtl/execute.sv
// EXEC stage of the 5-stage Beta pipeline: pipeline registers,
// ALU, and pc/link/LDR result selection toward MEM.
module execute
  import execute_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  execute_if.slave bus
);

  ex_regs_t    ex_d;
  ex_regs_t    ex_q;
  ex_ctl_t     ctl;
  logic [31:0] alu_y;
  logic [31:0] ldr_off;
  logic [31:0] y;

  always_comb begin
    ex_d    = ex_q;
    ex_d.pc = bus.pc_exec_next;
    ex_d.a  = bus.a_exec_next;
    ex_d.b  = bus.b_exec_next;
    ex_d.st = bus.st_exec_next;
    // Reserved source codes squash to NOP as well
    ex_d.ir = (bus.ir_src_exec == IR_SRC_DATA) ? bus.ir_exec_next : NOP;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_q <= '{pc: '0, ir: NOP, a: '0, b: '0, st: '0};
    end else begin
      ex_q <= ex_d;
    end
  end

  assign ctl     = decode(ex_q.ir[31:26]);
  assign ldr_off = {{14{ex_q.ir[15]}}, ex_q.ir[15:0], 2'b00};

  execute_alu u_alu (
    .a_i  (ex_q.a),
    .b_i  (ex_q.b),
    .fn_i (ctl.fn),
    .y_o  (alu_y)
  );

  always_comb begin
    y = '0;
    unique case (ctl.sel)
      SEL_ALU:  y = alu_y;
      SEL_PC:   y = ex_q.pc;
      SEL_LDR:  y = ex_q.pc + ldr_off;
      default:  y = '0;
    endcase
  end

  assign bus.pc_mem_next = ex_q.pc;
  assign bus.ir_mem_next = ex_q.ir;
  assign bus.y_mem_next  = y;
  assign bus.st_mem_next = ex_q.st;

endmodule

// File: tb/tb_execute.sv
// Directed self-checking bench for the Beta EXEC stage.
module tb_execute;
  import execute_pkg::*;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  execute_if bus ();

  execute dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [5:0] op,
                                     input logic [15:0] lit);
    return {op, 5'd1, 5'd2, lit};
  endfunction

  task automatic drive(input logic [1:0]  src,
                       input logic [31:0] pc,
                       input logic [31:0] ir,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [31:0] st);
    @(negedge clk);
    bus.ir_src_exec  = src;
    bus.pc_exec_next = pc;
    bus.ir_exec_next = ir;
    bus.a_exec_next  = a;
    bus.b_exec_next  = b;
    bus.st_exec_next = st;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    checks++;
    if (bus.pc_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_pc got=%h exp=%h", bus.pc_mem_next, 32'h0);
    end
    checks++;
    if (bus.ir_mem_next !== 32'h83FFF800) begin
      errors++;
      $display("FAIL reset_ir got=%h exp=%h", bus.ir_mem_next, 32'h83FFF800);
    end
    checks++;
    if (bus.y_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_y got=%h exp=%h", bus.y_mem_next, 32'h0);
    end
    checks++;
    if (bus.st_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL reset_st got=%h exp=%h", bus.st_mem_next, 32'h0);
    end
  endtask

  task automatic test_alu();
    logic [31:0] ins;
    ins = mk(6'h20, 16'h0000);
    drive(IR_SRC_DATA, 32'h4, ins, 32'd1, 32'd2, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd3) begin
      errors++;
      $display("FAIL add_y got=%h exp=%h", bus.y_mem_next, 32'd3);
    end
    checks++;
    if (bus.ir_mem_next !== ins) begin
      errors++;
      $display("FAIL add_ir got=%h exp=%h", bus.ir_mem_next, ins);
    end
    drive(IR_SRC_DATA, 32'h8, mk(6'h21, 16'h0), 32'd2, 32'd1, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd1) begin
      errors++;
      $display("FAIL sub_y got=%h exp=%h", bus.y_mem_next, 32'd1);
    end
    drive(IR_SRC_DATA, 32'hC, mk(6'h25, 16'h0), 32'hFFFFFFFF, 32'd0, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd1) begin
      errors++;
      $display("FAIL cmplt_y got=%h exp=%h", bus.y_mem_next, 32'd1);
    end
    drive(IR_SRC_DATA, 32'h10, mk(6'h2E, 16'h0), 32'h80000000, 32'd4, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'hF8000000) begin
      errors++;
      $display("FAIL sra_y got=%h exp=%h", bus.y_mem_next, 32'hF8000000);
    end
    drive(IR_SRC_DATA, 32'h14, mk(6'h32, 16'hFFFF), 32'd3, 32'hFFFFFFFF, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'hFFFFFFFD) begin
      errors++;
      $display("FAIL mulc_y got=%h exp=%h", bus.y_mem_next, 32'hFFFFFFFD);
    end
    drive(IR_SRC_DATA, 32'h18, mk(6'h2B, 16'h0), 32'hF0F0F0F0, 32'hFF00FF00, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'hF00FF00F) begin
      errors++;
      $display("FAIL xnor_y got=%h exp=%h", bus.y_mem_next, 32'hF00FF00F);
    end
    drive(IR_SRC_DATA, 32'h1C, mk(6'h36, 16'h5), 32'd5, 32'd5, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd1) begin
      errors++;
      $display("FAIL cmplec_y got=%h exp=%h", bus.y_mem_next, 32'd1);
    end
    drive(IR_SRC_DATA, 32'h20, mk(6'h23, 16'h0), 32'd100, 32'd5, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd0) begin
      errors++;
      $display("FAIL div_y got=%h exp=%h", bus.y_mem_next, 32'd0);
    end
  endtask

  task automatic test_branch_ldr();
    drive(IR_SRC_DATA, 32'h0, mk(6'h1F, 16'h0000), 32'h55, 32'h66, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL ldr0_y got=%h exp=%h", bus.y_mem_next, 32'h0);
    end
    drive(IR_SRC_DATA, 32'h100, mk(6'h1F, 16'hFFFF), 32'h55, 32'h66, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'hFC) begin
      errors++;
      $display("FAIL ldrm1_y got=%h exp=%h", bus.y_mem_next, 32'hFC);
    end
    drive(IR_SRC_DATA, 32'h40, mk(6'h1D, 16'h0010), 32'h55, 32'h66, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'h40) begin
      errors++;
      $display("FAIL bne_y got=%h exp=%h", bus.y_mem_next, 32'h40);
    end
  endtask

  task automatic test_store();
    drive(IR_SRC_DATA, 32'h44, mk(6'h19, 16'h0008), 32'h1000, 32'h8, 32'hDEADBEEF);
    checks++;
    if (bus.y_mem_next !== 32'h1008) begin
      errors++;
      $display("FAIL st_y got=%h exp=%h", bus.y_mem_next, 32'h1008);
    end
    checks++;
    if (bus.st_mem_next !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL st_data got=%h exp=%h", bus.st_mem_next, 32'hDEADBEEF);
    end
  endtask

  task automatic test_ir_nop();
    drive(IR_SRC_NOP, 32'h200, mk(6'h22, 16'h0), 32'd3, 32'd4, 32'h77);
    checks++;
    if (bus.ir_mem_next !== 32'h83FFF800) begin
      errors++;
      $display("FAIL nop_ir got=%h exp=%h", bus.ir_mem_next, 32'h83FFF800);
    end
    checks++;
    if (bus.pc_mem_next !== 32'h200) begin
      errors++;
      $display("FAIL nop_pc got=%h exp=%h", bus.pc_mem_next, 32'h200);
    end
    checks++;
    if (bus.y_mem_next !== 32'd7) begin
      errors++;
      $display("FAIL nop_y got=%h exp=%h", bus.y_mem_next, 32'd7);
    end
    drive(2'd3, 32'h204, mk(6'h22, 16'h0), 32'd3, 32'd4, 32'h0);
    checks++;
    if (bus.ir_mem_next !== 32'h83FFF800) begin
      errors++;
      $display("FAIL rsv_ir got=%h exp=%h", bus.ir_mem_next, 32'h83FFF800);
    end
  endtask

  task automatic test_boundaries();
    drive(IR_SRC_DATA, 32'h300, mk(6'h20, 16'h0), 32'h7FFFFFFF, 32'd1, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'h80000000) begin
      errors++;
      $display("FAIL add_wrap got=%h exp=%h", bus.y_mem_next, 32'h80000000);
    end
    drive(IR_SRC_DATA, 32'h304, mk(6'h25, 16'h0), 32'h80000000, 32'd1, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'd1) begin
      errors++;
      $display("FAIL cmplt_min got=%h exp=%h", bus.y_mem_next, 32'd1);
    end
    drive(IR_SRC_DATA, 32'h308, mk(6'h2C, 16'h0), 32'h1234, 32'd32, 32'h0);
    checks++;
    if (bus.y_mem_next !== 32'h1234) begin
      errors++;
      $display("FAIL shl32 got=%h exp=%h", bus.y_mem_next, 32'h1234);
    end
  endtask

  task automatic test_async_reset();
    drive(IR_SRC_DATA, 32'h400, mk(6'h20, 16'h0), 32'd5, 32'd6, 32'h99);
    checks++;
    if (bus.y_mem_next !== 32'd11) begin
      errors++;
      $display("FAIL pre_rst_y got=%h exp=%h", bus.y_mem_next, 32'd11);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (bus.ir_mem_next !== 32'h83FFF800) begin
      errors++;
      $display("FAIL async_ir got=%h exp=%h", bus.ir_mem_next, 32'h83FFF800);
    end
    checks++;
    if (bus.pc_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL async_pc got=%h exp=%h", bus.pc_mem_next, 32'h0);
    end
    checks++;
    if (bus.y_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL async_y got=%h exp=%h", bus.y_mem_next, 32'h0);
    end
    checks++;
    if (bus.st_mem_next !== 32'h0) begin
      errors++;
      $display("FAIL async_st got=%h exp=%h", bus.st_mem_next, 32'h0);
    end
    #1 rst = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    bus.ir_src_exec  = IR_SRC_DATA;
    bus.pc_exec_next = 32'h0;
    bus.ir_exec_next = 32'h0;
    bus.a_exec_next  = 32'h0;
    bus.b_exec_next  = 32'h0;
    bus.st_exec_next = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk);
    rst = 1'b0;
    test_alu();
    test_branch_ldr();
    test_store();
    test_ir_nop();
    test_boundaries();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
